// File: rtl/eth_phy_10g_tx_gearbox_if.sv
// Block-side and line-side signals of the 10G TX 66b->64b gearbox.
// master drives the offered block; slave is the gearbox.
interface eth_phy_10g_tx_gearbox_if #(
    parameter int HDR_WIDTH  = 2,
    parameter int DATA_WIDTH = 64
);
    logic [HDR_WIDTH-1:0]  i_tx_hdr;
    logic [DATA_WIDTH-1:0] i_tx_data;
    logic                  i_tx_valid;
    logic                  o_tx_ready;
    logic [DATA_WIDTH-1:0] o_serdes_tx_data;
    logic                  o_underrun;
    logic [15:0]           o_underrun_count;

    modport master (
        output i_tx_hdr, i_tx_data, i_tx_valid,
        input  o_tx_ready, o_serdes_tx_data, o_underrun, o_underrun_count
    );

    modport slave (
        input  i_tx_hdr, i_tx_data, i_tx_valid,
        output o_tx_ready, o_serdes_tx_data, o_underrun, o_underrun_count
    );
endinterface

// File: rtl/eth_phy_10g_tx_gearbox.sv
// 66b->64b TX gearbox: one block per cycle in, one 64-bit word per cycle out, line word 1 cycle after consume.
// Pauses upstream 1 cycle in 33 (ready low); missing blocks become idle blocks. Optional counter: TX_GEARBOX_UNDERRUN_CNT_EN.
module eth_phy_10g_tx_gearbox #(
    parameter int HDR_WIDTH  = 2,
    parameter int DATA_WIDTH = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    eth_phy_10g_tx_gearbox_if.slave     bus
);
    localparam int BLK_W = HDR_WIDTH + DATA_WIDTH;
    localparam int CAT_W = BLK_W + DATA_WIDTH;
    localparam logic [BLK_W-1:0] IDLE_BLK = {{(DATA_WIDTH-8){1'b0}}, 8'h1E, 2'b01};

    logic                  running;
    logic [5:0]            phase;
    logic [BLK_W-1:0]      residual;
    logic [DATA_WIDTH-1:0] line_q;
    logic                  underrun_q;

    logic                  ready;
    logic                  pause;
    logic [6:0]            offset;
    logic [BLK_W-1:0]      blk;
    logic [CAT_W-1:0]      cat;

    assign pause = (phase == 6'd32);
    assign ready = running && !pause;

    // New block lands just above the 2*phase pending bits, which stay LSB-aligned.
    always_comb begin
        offset = {phase, 1'b0};
        blk    = bus.i_tx_valid ? {bus.i_tx_data, bus.i_tx_hdr} : IDLE_BLK;
        cat    = ({{DATA_WIDTH{1'b0}}, blk} << offset) | {{DATA_WIDTH{1'b0}}, residual};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            running    <= 1'b0;
            phase      <= 6'd0;
            residual   <= '0;
            line_q     <= '0;
            underrun_q <= 1'b0;
        end else begin
            running <= 1'b1;
            if (running) begin
                if (pause) begin
                    phase      <= 6'd0;
                    line_q     <= residual[DATA_WIDTH-1:0];
                    residual   <= '0;
                    underrun_q <= 1'b0;
                end else begin
                    phase      <= phase + 6'd1;
                    line_q     <= cat[DATA_WIDTH-1:0];
                    residual   <= cat[CAT_W-1:DATA_WIDTH];
                    underrun_q <= !bus.i_tx_valid;
                end
            end
        end
    end

    assign bus.o_tx_ready       = ready;
    assign bus.o_serdes_tx_data = line_q;
    assign bus.o_underrun       = underrun_q;

`ifdef TX_GEARBOX_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;

    // Counts in step with the pulse so both become visible in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underrun_cnt <= 16'h0000;
        end else if (ready && !bus.i_tx_valid && underrun_cnt != 16'hFFFF) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end

    assign bus.o_underrun_count = underrun_cnt;
`else
    assign bus.o_underrun_count = 16'h0000;
`endif
endmodule
